mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (fetch / load-store) arbiter onto a single-outstanding unified memory port.
// Requests are latched on grant; completion data is registered and pulsed for one cycle.
module mem_arbiter #(
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   // instruction client
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_data_ok,
   // data client
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_data_ok,
   // unified memory
   output logic        mem_req,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        stall
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_ADDR = 3'd1,
      I_WAIT = 3'd2,
      D_ADDR = 3'd3,
      D_WAIT = 3'd4
   } state_e;

   state_e      state_q, state_d;

   logic [3:0]  mem_wen_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [31:0] inst_rdata_q, data_rdata_q;
   logic        inst_data_ok_q, data_data_ok_q;

   logic        inst_grantable, data_grantable;
   logic        pick_inst, pick_data;
   logic        grant_inst, grant_data;
   logic        done_inst, done_data;

   // A client whose completion pulse is showing still holds its old request high.
   assign inst_grantable = inst_req & ~inst_data_ok_q;
   assign data_grantable = data_req & ~data_data_ok_q;
   assign pick_data      = data_grantable & (DATA_FIRST | ~inst_grantable);
   assign pick_inst      = inst_grantable & ~pick_data;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_data)      state_d = D_ADDR;
            else if (pick_inst) state_d = I_ADDR;
         end
         I_ADDR: begin
            // accept and return in the same cycle counts as completion
            if (mem_addr_ok) state_d = mem_data_ok ? IDLE : I_WAIT;
         end
         I_WAIT: begin
            if (mem_data_ok) state_d = IDLE;
         end
         D_ADDR: begin
            if (mem_addr_ok) state_d = mem_data_ok ? IDLE : D_WAIT;
         end
         D_WAIT: begin
            if (mem_data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      mem_req    = 1'b0;
      grant_inst = 1'b0;
      grant_data = 1'b0;
      done_inst  = 1'b0;
      done_data  = 1'b0;
      case (state_q)
         IDLE: begin
            grant_inst = pick_inst;
            grant_data = pick_data;
         end
         I_ADDR: begin
            mem_req   = 1'b1;
            done_inst = mem_addr_ok & mem_data_ok;
         end
         I_WAIT: done_inst = mem_data_ok;
         D_ADDR: begin
            mem_req   = 1'b1;
            done_data = mem_addr_ok & mem_data_ok;
         end
         D_WAIT: done_data = mem_data_ok;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- request latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wen_q   <= 4'b0000;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else if (grant_data) begin
         mem_wen_q   <= data_wen;
         mem_addr_q  <= data_addr;
         mem_wdata_q <= data_wdata;
      end else if (grant_inst) begin
         mem_wen_q   <= 4'b0000;
         mem_addr_q  <= inst_addr;
         mem_wdata_q <= 32'h0;
      end
   end

   // ---------------------------------------------------------------- completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_rdata_q   <= 32'h0;
         data_rdata_q   <= 32'h0;
         inst_data_ok_q <= 1'b0;
         data_data_ok_q <= 1'b0;
      end else begin
         inst_data_ok_q <= done_inst;
         data_data_ok_q <= done_data;
         if (done_inst) inst_rdata_q <= mem_rdata;
         if (done_data) data_rdata_q <= mem_rdata;
      end
   end

   assign mem_wen      = mem_wen_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;
   assign inst_data_ok = inst_data_ok_q;
   assign data_data_ok = data_data_ok_q;

   assign stall = (inst_req & ~inst_data_ok_q) | (data_req & ~data_data_ok_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, back-pressure, slow data,
// reset abort, re-grant guard and stray memory handshakes while idle.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_data_ok;
   logic        mem_req;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        stall;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .stall(stall)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // advance one cycle; inputs are then driven at edge+1, checks at edge+2
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_req"},  {31'h0, mem_req}, 32'h0);
      chk({tag, ".mem_wen"},  {28'h0, mem_wen}, 32'h0);
      chk({tag, ".mem_addr"}, mem_addr, 32'h0);
      chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, ".inst_rdata"}, inst_rdata, 32'h0);
      chk({tag, ".data_rdata"}, data_rdata, 32'h0);
      chk({tag, ".inst_ok"}, {31'h0, inst_data_ok}, 32'h0);
      chk({tag, ".data_ok"}, {31'h0, data_data_ok}, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      repeat (3) tick();
      settle();
      chk_all_zero("reset");

      // ---- fetch only; request raised together with reset release
      rst = 1'b0;
      inst_req = 1; inst_addr = 32'hBFC00000;
      settle();
      chk("f.stall0", {31'h0, stall}, 32'h1);
      chk("f.req0", {31'h0, mem_req}, 32'h0);
      tick();
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h24080001;
      settle();
      chk("f.req1", {31'h0, mem_req}, 32'h1);
      chk("f.addr1", mem_addr, 32'hBFC00000);
      chk("f.wen1", {28'h0, mem_wen}, 32'h0);
      tick();
      mem_addr_ok = 0; mem_data_ok = 0; inst_req = 0;
      settle();
      chk("f.ok2", {31'h0, inst_data_ok}, 32'h1);
      chk("f.rdata2", inst_rdata, 32'h24080001);
      chk("f.dok2", {31'h0, data_data_ok}, 32'h0);
      chk("f.req2", {31'h0, mem_req}, 32'h0);
      tick();
      settle();
      chk("f.ok3", {31'h0, inst_data_ok}, 32'h0);

      // ---- contention: store wins, then fetch
      inst_req = 1; inst_addr = 32'hBFC00004;
      data_req = 1; data_wen = 4'hF; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
      settle();
      chk("c.stall0", {31'h0, stall}, 32'h1);
      tick();
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0;
      settle();
      chk("c.req1", {31'h0, mem_req}, 32'h1);
      chk("c.addr1", mem_addr, 32'h80000010);
      chk("c.wen1", {28'h0, mem_wen}, 32'hF);
      chk("c.wdata1", mem_wdata, 32'hDEADBEEF);
      chk("c.stall1", {31'h0, stall}, 32'h1);
      tick();
      mem_addr_ok = 0; mem_data_ok = 0; data_req = 0;
      settle();
      chk("c.dok2", {31'h0, data_data_ok}, 32'h1);
      chk("c.iok2", {31'h0, inst_data_ok}, 32'h0);
      chk("c.stall2", {31'h0, stall}, 32'h1);
      chk("c.req2", {31'h0, mem_req}, 32'h0);
      tick();
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h11112222;
      settle();
      chk("c.req3", {31'h0, mem_req}, 32'h1);
      chk("c.addr3", mem_addr, 32'hBFC00004);
      chk("c.wen3", {28'h0, mem_wen}, 32'h0);
      chk("c.wdata3", mem_wdata, 32'h0);
      chk("c.dok3", {31'h0, data_data_ok}, 32'h0);
      chk("c.stall3", {31'h0, stall}, 32'h1);
      tick();
      mem_addr_ok = 0; mem_data_ok = 0;
      settle();
      chk("c.iok4", {31'h0, inst_data_ok}, 32'h1);
      chk("c.irdata4", inst_rdata, 32'h11112222);
      chk("c.stall4", {31'h0, stall}, 32'h0);
      inst_req = 0;
      tick();

      // ---- stray handshakes and idle client activity are ignored
      inst_addr = 32'h0BAD0000; data_addr = 32'h0BAD0004; data_wen = 4'h3;
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h55555555;
      tick();
      mem_addr_ok = 0; mem_data_ok = 0;
      settle();
      chk("i.req", {31'h0, mem_req}, 32'h0);
      chk("i.iok", {31'h0, inst_data_ok}, 32'h0);
      chk("i.dok", {31'h0, data_data_ok}, 32'h0);
      chk("i.irdata", inst_rdata, 32'h11112222);
      chk("i.addr", mem_addr, 32'hBFC00004);

      // ---- back-pressure then slow data on a load
      data_req = 1; data_wen = 4'h0; data_addr = 32'h80001000; data_wdata = 32'h0;
      tick();
      for (int i = 0; i < 6; i++) begin
         data_addr = 32'h80001000 + 32'(i + 1) * 4;  // fields must stay latched
         mem_addr_ok = (i == 5);
         settle();
         chk("bp.req", {31'h0, mem_req}, 32'h1);
         chk("bp.addr", mem_addr, 32'h80001000);
         tick();
      end
      mem_addr_ok = 0;
      for (int j = 0; j < 3; j++) begin
         mem_data_ok = (j == 2);
         mem_rdata = (j == 2) ? 32'h12345678 : 32'hFFFFFFFF;
         settle();
         chk("sd.req", {31'h0, mem_req}, 32'h0);
         chk("sd.dok", {31'h0, data_data_ok}, 32'h0);
         tick();
      end
      mem_data_ok = 0; data_req = 0;
      settle();
      chk("sd.dok1", {31'h0, data_data_ok}, 32'h1);
      chk("sd.rdata", data_rdata, 32'h12345678);
      chk("sd.req1", {31'h0, mem_req}, 32'h0);
      tick();
      settle();
      chk("sd.dok2", {31'h0, data_data_ok}, 32'h0);
      chk("sd.req2", {31'h0, mem_req}, 32'h0);

      // ---- reset abort in I_WAIT
      inst_req = 1; inst_addr = 32'hBFC00008;
      tick();
      mem_addr_ok = 1; mem_data_ok = 0;
      settle();
      chk("ra.req1", {31'h0, mem_req}, 32'h1);
      chk("ra.addr1", mem_addr, 32'hBFC00008);
      tick();
      mem_addr_ok = 0;
      settle();
      chk("ra.req2", {31'h0, mem_req}, 32'h0);
      rst = 1; inst_req = 0;
      settle();
      chk_all_zero("ra.rst");
      tick();
      rst = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD0000;
      tick();
      mem_data_ok = 0;
      settle();
      chk_all_zero("ra.post1");
      tick();
      settle();
      chk_all_zero("ra.post2");

      // ---- re-grant guard: request held across its completion pulse
      inst_req = 1; inst_addr = 32'hBFC0000C;
      tick();
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hABCD0001;
      settle();
      chk("rg.req1", {31'h0, mem_req}, 32'h1);
      tick();
      mem_addr_ok = 0; mem_data_ok = 0; inst_addr = 32'hBFC00010;
      settle();
      chk("rg.ok2", {31'h0, inst_data_ok}, 32'h1);
      chk("rg.rdata2", inst_rdata, 32'hABCD0001);
      chk("rg.req2", {31'h0, mem_req}, 32'h0);
      tick();
      settle();
      chk("rg.ok3", {31'h0, inst_data_ok}, 32'h0);
      chk("rg.req3", {31'h0, mem_req}, 32'h0);
      chk("rg.stall3", {31'h0, stall}, 32'h1);
      tick();
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hABCD0002;
      settle();
      chk("rg.req4", {31'h0, mem_req}, 32'h1);
      chk("rg.addr4", mem_addr, 32'hBFC00010);
      tick();
      mem_addr_ok = 0; mem_data_ok = 0; inst_req = 0;
      settle();
      chk("rg.ok5", {31'h0, inst_data_ok}, 32'h1);
      chk("rg.rdata5", inst_rdata, 32'hABCD0002);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
